// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: N inputs in, M saturated outputs out, P MACs in parallel.
// Optional RELU_EN macro clamps negative results to zero.
module fc_layer_stream #(
    parameter  int N    = 4,
    parameter  int M    = 8,
    parameter  int T    = 16,
    parameter  int P    = 1,
    parameter  int FRAC = 0,
    localparam int AW   = (M * N > 1) ? $clog2(M * N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                input_valid,
    output logic                input_ready,
    input  logic signed [T-1:0] input_data,
    output logic                output_valid,
    input  logic                output_ready,
    output logic signed [T-1:0] output_data,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic signed [T-1:0] w_data,
    output logic                w_ready
);

    localparam int NP   = M / P;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = (NP > 1) ? $clog2(NP) : 1;
    localparam int IW   = (P > 1) ? $clog2(P) : 1;
    localparam int PRW  = 2 * T;
    localparam int ACCW = 2 * T + $clog2(N);

    localparam logic signed [ACCW-1:0] SMAX =
        {{(ACCW - T + 1){1'b0}}, {(T - 1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN =
        {{(ACCW - T + 1){1'b1}}, {(T - 1){1'b0}}};

`ifdef RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef enum logic [1:0] {LOAD, MAC, FIN, DRAIN} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [PW-1:0]          pass_q;
    logic [IW-1:0]          idx_q;
    logic signed [T-1:0]    x_q     [N];
    logic signed [T-1:0]    w_mem   [M*N];
    logic signed [ACCW-1:0] acc_q   [P];
    logic signed [T-1:0]    res_q   [P];
    logic                   in_rdy_q;
    logic                   out_vld_q;
    logic                   w_rdy_q;
    logic signed [T-1:0]    out_data_q;

    logic signed [PRW-1:0]  x_ext;
    logic signed [PRW-1:0]  w_ext   [P];
    logic signed [PRW-1:0]  prod    [P];
    logic signed [ACCW-1:0] sh      [P];
    logic signed [T-1:0]    res_d   [P];
    logic [AW-1:0]          widx    [P];
    logic [IW-1:0]          idx_nx;
    logic                   w_in_range;

    assign input_ready  = in_rdy_q;
    assign output_valid = out_vld_q;
    assign output_data  = out_data_q;
    assign w_ready      = w_rdy_q;

    assign idx_nx     = idx_q + 1'b1;
    assign w_in_range = {1'b0, w_addr} < (AW + 1)'(M * N);
    assign x_ext      = PRW'(x_q[cnt_q]);

    always_comb begin
        for (int p = 0; p < P; p++) begin
            widx[p]  = AW'(((int'(pass_q) * P + p) * N) + int'(cnt_q));
            w_ext[p] = PRW'(w_mem[widx[p]]);
            prod[p]  = x_ext * w_ext[p];
            sh[p]    = acc_q[p] >>> FRAC;
            if (sh[p] > SMAX)
                res_d[p] = SMAX[T-1:0];
            else if (sh[p] < SMIN)
                res_d[p] = SMIN[T-1:0];
            else
                res_d[p] = sh[p][T-1:0];
            if (RELU && res_d[p][T-1])
                res_d[p] = '0;
        end
    end

    // Weight memory has no reset so loaded weights survive a frame abort.
    always_ff @(posedge clk) begin
        if (w_we && w_rdy_q && w_in_range)
            w_mem[w_addr] <= w_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            pass_q     <= '0;
            idx_q      <= '0;
            in_rdy_q   <= 1'b1;
            out_vld_q  <= 1'b0;
            w_rdy_q    <= 1'b1;
            out_data_q <= '0;
            for (int n = 0; n < N; n++) x_q[n] <= '0;
            for (int p = 0; p < P; p++) begin
                acc_q[p] <= '0;
                res_q[p] <= '0;
            end
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (input_valid) begin
                        x_q[cnt_q] <= input_data;
                        w_rdy_q    <= 1'b0;
                        if (cnt_q == CW'(N - 1)) begin
                            cnt_q    <= '0;
                            pass_q   <= '0;
                            in_rdy_q <= 1'b0;
                            state_q  <= MAC;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                MAC: begin
                    for (int p = 0; p < P; p++)
                        acc_q[p] <= acc_q[p] + ACCW'(prod[p]);
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_q   <= '0;
                        state_q <= FIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIN: begin
                    for (int p = 0; p < P; p++) begin
                        res_q[p] <= res_d[p];
                        acc_q[p] <= '0;
                    end
                    out_data_q <= res_d[0];
                    idx_q      <= '0;
                    out_vld_q  <= 1'b1;
                    state_q    <= DRAIN;
                end
                DRAIN: begin
                    if (output_ready) begin
                        if (idx_q == IW'(P - 1)) begin
                            idx_q     <= '0;
                            out_vld_q <= 1'b0;
                            if (pass_q == PW'(NP - 1)) begin
                                pass_q   <= '0;
                                in_rdy_q <= 1'b1;
                                w_rdy_q  <= 1'b1;
                                state_q  <= LOAD;
                            end else begin
                                pass_q  <= pass_q + 1'b1;
                                state_q <= MAC;
                            end
                        end else begin
                            idx_q      <= idx_nx;
                            out_data_q <= res_q[idx_nx];
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream with N=4, M=8, T=16, P=2.
// Each scenario task drives its own stimulus and checks inline.
module tb_fc_layer_stream;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               input_valid = 1'b0;
    logic               input_ready;
    logic signed [15:0] input_data = '0;
    logic               output_valid;
    logic               output_ready = 1'b0;
    logic signed [15:0] output_data;
    logic               w_we = 1'b0;
    logic [4:0]         w_addr = '0;
    logic signed [15:0] w_data = '0;
    logic               w_ready;

    int n_vec = 0;
    int n_err = 0;

    logic signed [15:0] xin [4];
    logic signed [15:0] got [8];
    int got_n;
    int gaps;

    fc_layer_stream #(.N(4), .M(8), .T(16), .P(2), .FRAC(0)) dut (
        .clk(clk), .reset(reset),
        .input_valid(input_valid), .input_ready(input_ready),
        .input_data(input_data),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_data(output_data),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .w_ready(w_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: every weight = val; mode 1: W[m*4+n] = m+n-2
    task automatic load_weights(input int mode, input logic [15:0] val);
        for (int i = 0; i < 32; i++) begin
            w_we   = 1'b1;
            w_addr = 5'(i);
            w_data = (mode == 0) ? val : 16'(i / 4 + i % 4 - 2);
            tick();
        end
        w_we = 1'b0;
    endtask

    task automatic send_frame(input bit wr5, input logic [15:0] wval);
        for (int i = 0; i < 4; i++) begin
            int k = 0;
            input_valid = 1'b1;
            input_data  = xin[i];
            if (i == 0 && wr5) begin
                w_we   = 1'b1;
                w_addr = 5'd5;
                w_data = wval;
            end
            while (!input_ready && k < 100) begin
                tick();
                k++;
            end
            if (k >= 100) begin
                n_vec++;
                n_err++;
                $display("FAIL input_ready_timeout got=0 want=1");
            end
            tick();
            w_we = 1'b0;
        end
        input_valid = 1'b0;
    endtask

    // Receives 8 words with output_ready=1; optionally strobes a weight
    // write while the block is busy.
    task automatic collect(input bit spam);
        int  cyc = 0;
        bit  started = 0;
        got_n = 0;
        gaps  = 0;
        while (got_n < 8 && cyc < 600) begin
            output_ready = 1'b1;
            w_we   = spam && !w_ready;
            w_addr = 5'd5;
            w_data = 16'sd100;
            if (output_valid) begin
                got[got_n] = output_data;
                got_n++;
                started = 1;
            end else if (started) begin
                gaps++;
            end
            tick();
            cyc++;
        end
        w_we = 1'b0;
        output_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_vec += 4;
        if (input_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_input_ready got=%b want=1", input_ready);
        end
        if (output_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_output_valid got=%b want=0", output_valid);
        end
        if (output_data !== 16'sd0) begin
            n_err++;
            $display("FAIL reset_output_data got=%0d want=0", output_data);
        end
        if (w_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_w_ready got=%b want=1", w_ready);
        end
    endtask

    task automatic test_basic();
        int k = 0;
        load_weights(0, 16'sd1);
        xin = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        send_frame(0, '0);
        while (!output_valid && k < 50) begin
            tick();
            k++;
        end
        n_vec++;
        if (k !== 5) begin
            n_err++;
            $display("FAIL basic_latency got=%0d want=5", k);
        end
        collect(0);
        n_vec++;
        if (got_n !== 8) begin
            n_err++;
            $display("FAIL basic_count got=%0d want=8", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            n_vec++;
            if (got[i] !== 16'sd10) begin
                n_err++;
                $display("FAIL basic_out[%0d] got=%0d want=10", i, got[i]);
            end
        end
        n_vec += 3;
        if (gaps !== 15) begin
            n_err++;
            $display("FAIL basic_pass_gaps got=%0d want=15", gaps);
        end
        if (input_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_next_ready got=%b want=1", input_ready);
        end
        if (output_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_valid_after got=%b want=0", output_valid);
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] want_neg;
`ifdef RELU_EN
        want_neg = 16'sd0;
`else
        want_neg = 16'sh8000;
`endif
        load_weights(0, 16'h7FFF);
        xin = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
        send_frame(0, '0);
        collect(0);
        n_vec++;
        if (got_n !== 8) begin
            n_err++;
            $display("FAIL sat_pos_count got=%0d want=8", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            n_vec++;
            if (got[i] !== 16'sh7FFF) begin
                n_err++;
                $display("FAIL sat_pos[%0d] got=%h want=7fff", i, got[i]);
            end
        end
        load_weights(0, 16'h8000);
        send_frame(0, '0);
        collect(0);
        n_vec++;
        if (got_n !== 8) begin
            n_err++;
            $display("FAIL sat_neg_count got=%0d want=8", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            n_vec++;
            if (got[i] !== want_neg) begin
                n_err++;
                $display("FAIL sat_neg[%0d] got=%h want=%h",
                         i, got[i], want_neg);
            end
        end
    endtask

    task automatic test_backpressure();
        int  cyc = 0;
        bit  prev_stall = 0;
        bit  rdy;
        logic signed [15:0] prev_data = '0;
        load_weights(1, '0);
        xin = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        send_frame(0, '0);
        got_n = 0;
        while (got_n < 8 && cyc < 2000) begin
            if (prev_stall) begin
                n_vec++;
                if (output_valid !== 1'b1 || output_data !== prev_data) begin
                    n_err++;
                    $display("FAIL bp_hold got=%b/%0d want=1/%0d",
                             output_valid, output_data, prev_data);
                end
            end
            rdy = 1'($urandom_range(0, 1));
            output_ready = rdy;
            if (output_valid && rdy) begin
                got[got_n] = output_data;
                got_n++;
            end
            prev_stall = output_valid && !rdy;
            prev_data  = output_data;
            tick();
            cyc++;
        end
        output_ready = 1'b1;
        n_vec += 2;
        if (got_n !== 8) begin
            n_err++;
            $display("FAIL bp_count got=%0d want=8", got_n);
        end
        if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_extra_word got=%b/%b want=0/1",
                     output_valid, input_ready);
        end
        for (int i = 0; i < got_n; i++) begin
            n_vec++;
            if (got[i] !== 16'(10 * i)) begin
                n_err++;
                $display("FAIL bp_order[%0d] got=%0d want=%0d",
                         i, got[i], 10 * i);
            end
        end
        output_ready = 1'b0;
    endtask

    task automatic test_weight_port();
        send_frame(0, '0);
        collect(1);
        n_vec++;
        if (got_n !== 8 || got[1] !== 16'sd10 || got[7] !== 16'sd70) begin
            n_err++;
            $display("FAIL wp_busy_write got=%0d/%0d/%0d want=8/10/70",
                     got_n, got[1], got[7]);
        end
        send_frame(1, 16'sd3);
        collect(0);
        n_vec += 3;
        if (got[0] !== 16'sd0) begin
            n_err++;
            $display("FAIL wp_n0 got=%0d want=0", got[0]);
        end
        if (got[1] !== 16'sd16) begin
            n_err++;
            $display("FAIL wp_n1 got=%0d want=16", got[1]);
        end
        if (got[2] !== 16'sd20) begin
            n_err++;
            $display("FAIL wp_n2 got=%0d want=20", got[2]);
        end
    endtask

    task automatic test_reset_drain();
        int k = 0;
        send_frame(0, '0);
        while (!output_valid && k < 50) begin
            tick();
            k++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (output_valid !== 1'b0 || k >= 50) begin
            n_err++;
            $display("FAIL rst_async_valid got=%b want=0", output_valid);
        end
        tick();
        reset = 1'b0;
        input_valid = 1'b1;
        input_data  = 16'sd99;
        tick();
        tick();
        input_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_frame(0, '0);
        collect(0);
        n_vec++;
        if (got_n !== 8) begin
            n_err++;
            $display("FAIL rst_count got=%0d want=8", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            logic signed [15:0] want;
            want = (i == 1) ? 16'sd16 : 16'(10 * i);
            n_vec++;
            if (got[i] !== want) begin
                n_err++;
                $display("FAIL rst_out[%0d] got=%0d want=%0d", i, got[i], want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_weight_port();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer_stream.md
# fc_layer_stream

Parametrised, weight-loadable fully-connected layer with a valid/ready stream interface on input and output. Each frame is N signed T-bit inputs, consumed one per handshake. The block computes M outputs with P parallel multiply-accumulate units, saturates them and streams them out in order. It replaces the fixed per-layer generated FC instances inside the network tops, and chains directly: output stream of layer k feeds input stream of layer k+1.

## Interface
- N, 4: inputs per frame (≥1)
- M, 8: outputs per frame (≥1; M % P == 0)
- T, 16: data/weight width, signed two's complement
- P, 1: parallel MAC units
- FRAC, 0: arithmetic right-shift applied to accumulator before saturation
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all control/data registers (weight memory retained)
- input_valid  in  1  input word valid
- input_ready  out  1  block accepts input word
- input_data  in  T  signed input word
- output_valid  out  1  output word valid
- output_ready  in  1  downstream accepts output word
- output_data  out  T  signed output word
- w_we  in  1  weight write strobe
- w_addr  in  $clog2(M*N)  weight address, m*N+n
- w_data  in  T  signed weight value
- w_ready  out  1  weight write accepted this cycle

## Operation
- States: LOAD, MAC, FIN, DRAIN.
- LOAD: input_ready=1. A word transfers when input_valid&&input_ready and is written to x[cnt]; cnt increments. The transfer with cnt==N-1 moves to MAC, pass=0.
- MAC: N cycles. Cycle n: unit p does acc[p] += x[n] * W[(pass*P+p)*N+n]. The product is full 2T bits. Accumulator width is 2T+$clog2(N) bits, with no overflow possible.
- FIN: 1 cycle. res[p] = sat_T(acc[p] >>> FRAC), clamped to [-2^(T-1), 2^(T-1)-1]. acc cleared.
- DRAIN: output_valid=1, output_data=res[idx], with idx 0..P-1. idx advances on output_valid&&output_ready. The last transfer goes to MAC with pass+1 if pass<M/P-1, else to LOAD.
- Output order: neuron 0..M-1 strictly ascending.
- Input and compute do not overlap. input_ready=0 outside LOAD.
- w_ready=1 only in LOAD with cnt==0. A write is then committed the same edge. w_we while w_ready=0 is ignored.
- An out-of-range w_addr (≥M*N) is ignored.
- Simultaneous w_we and input handshake in LOAD/cnt==0: both performed. The weight write is visible to this frame.

## Timing
- Reset values: input_ready=1, output_valid=0, output_data=0, w_ready=1. State=LOAD, cnt=idx=pass=0, acc=0.
- Reset mid-frame aborts the frame. Partial inputs and results are discarded, and the next frame starts clean.
- First output_valid occurs N+1 cycles after the last input handshake (N MAC + 1 FIN).
- Between passes: N+1 cycles with output_valid=0.
- Frame throughput with output_ready held 1: N + (M/P)(N+1+P) cycles.
- output_data is held stable while output_valid&&!output_ready.
- The datapath is registered, with no combinational path from input_valid or output_ready to any output.

## Configuration
- RELU_EN defined: res[p] = max(0, sat_T(...)); negative results are emitted as 0.
- RELU_EN undefined: signed saturated results pass through unchanged.

## Test plan
- Reset, then check the idle outputs: input_ready=1, output_valid=0, output_data=0, w_ready=1.
- N=4, M=8, P=2, all weights 1, inputs {1,2,3,4}, output_ready=1:
  - 8 outputs of 10.
  - First valid 5 cycles after the 4th input.
  - Next input_ready 1 cycle after the 8th output.
- Saturation, T=16:
  - Weights 0x7FFF and inputs 0x7FFF everywhere -> all outputs 0x7FFF.
  - Weights 0x8000 with inputs 0x7FFF -> 0x8000 without RELU_EN, 0 with RELU_EN.
- Backpressure: output_ready toggled randomly. Outputs are unchanged while stalled, no word is lost or duplicated, and the order is 0..M-1.
- Weight port:
  - w_we asserted during MAC or DRAIN has no effect.
  - A write of W[5]=3 in LOAD/cnt==0 changes neuron 1 (N=4) in the very next frame.
- Reset asserted during DRAIN: output_valid drops asynchronously. The next full frame gives correct results with the weights retained.
